// File: rtl/audio_pkg.sv
// audio_post shared types and helpers.
// Sample type, width constant and the 16-bit saturator.
package audio_pkg;

  localparam int AUDIO_W = 16;

  typedef logic signed [AUDIO_W-1:0] audio_sample_t;

  typedef struct packed {
    audio_sample_t val;
    logic          ovf;
  } sat_t;

  // Clip a sign-extended value to the 16-bit range and flag overflow.
  function automatic sat_t sat16(input logic signed [31:0] x);
    sat_t r;
    r.val = x[AUDIO_W-1:0];
    r.ovf = 1'b0;
    if (x > 32'sd32767) begin
      r.val = 16'sh7fff;
      r.ovf = 1'b1;
    end else if (x < -32'sd32768) begin
      r.val = 16'sh8000;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/audio_post_if.sv
// audio_post bus: sample input, controls and output pair.
// master drives sound and controls, slave is the audio_post block.
interface audio_post_if;
  import audio_pkg::*;

  logic          ce_in;
  audio_sample_t sound_in;
  logic [3:0]    volume;
  logic          mute;
  logic          dc_en;
  logic          clip_clr;
  audio_sample_t audio_l;
  audio_sample_t audio_r;
  logic          sample_valid;
  logic          clip;

  modport master (
    output ce_in, sound_in, volume,
    output mute, dc_en, clip_clr,
    input  audio_l, audio_r,
    input  sample_valid, clip
  );

  modport slave (
    input  ce_in, sound_in, volume,
    input  mute, dc_en, clip_clr,
    output audio_l, audio_r,
    output sample_valid, clip
  );
endinterface

// File: rtl/audio_dc_blocker.sv
// First-order IIR DC blocker stage.
// Output is 17 bits so a large step is kept for the saturator.
module audio_dc_blocker
  import audio_pkg::*;
#(
  parameter int DC_SHIFT = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  audio_sample_t             in_sample,
  input  logic                      dc_en,
  output logic                      out_valid,
  output logic signed [AUDIO_W:0]   out_sample
);

  localparam int ACC_W = AUDIO_W + DC_SHIFT + 1;

  logic signed [ACC_W-1:0]   r_dc_acc;
  logic signed [AUDIO_W:0]   w_est;
  logic signed [AUDIO_W:0]   w_x;
  logic signed [AUDIO_W:0]   w_y;
  logic signed [ACC_W-1:0]   w_y_ext;

  assign w_est   = (AUDIO_W+1)'(r_dc_acc >>> DC_SHIFT);
  assign w_x     = {in_sample[AUDIO_W-1], in_sample};
  assign w_y     = w_x - w_est;
  assign w_y_ext = {{(ACC_W-AUDIO_W-1){w_y[AUDIO_W]}}, w_y};

  // Subtract the running DC estimate and fold the residue back in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dc_acc   <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        if (dc_en) begin
          out_sample <= w_y;
          r_dc_acc   <= r_dc_acc + w_y_ext;
        end else begin
          out_sample <= w_x;
        end
      end
    end
  end

endmodule

// File: rtl/audio_post.sv
// Audio post-processing: boxcar decimator, DC blocker,
// volume/mute, 16-bit saturation and sticky clip flag.
module audio_post
  import audio_pkg::*;
#(
  parameter int DECIM_LOG2 = 4,
  parameter int DC_SHIFT   = 10
) (
  input logic         clk,
  input logic         reset,
  audio_post_if.slave bus
);

  localparam int ACC_W = AUDIO_W + DECIM_LOG2;

  logic                    r_ce;
  audio_sample_t           r_snd;
  logic [DECIM_LOG2-1:0]   r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_s1_valid;
  audio_sample_t           r_s1;
  audio_sample_t           r_audio;
  logic                    r_valid;
  logic                    r_clip;

  logic signed [ACC_W-1:0] w_sum;
  audio_sample_t           w_avg;
  logic                    w_s2_valid;
  logic signed [AUDIO_W:0] w_s2;
  logic signed [AUDIO_W:0] w_z;
  logic signed [31:0]      w_z32;
  sat_t                    w_sat;

  assign w_sum = r_acc + {{DECIM_LOG2{r_snd[AUDIO_W-1]}}, r_snd};
  assign w_avg = AUDIO_W'(w_sum >>> DECIM_LOG2);

  // Register the tick strobe and sample at the block boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ce  <= 1'b0;
      r_snd <= '0;
    end else begin
      r_ce  <= bus.ce_in;
      r_snd <= bus.sound_in;
    end
  end

  // Accumulate one window and emit its floor average.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else begin
      r_s1_valid <= 1'b0;
      if (r_ce) begin
        r_cnt <= r_cnt + 1'b1;
        if (&r_cnt) begin
          r_acc      <= '0;
          r_s1       <= w_avg;
          r_s1_valid <= 1'b1;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

  audio_dc_blocker #(
    .DC_SHIFT (DC_SHIFT)
  ) u_dc (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (r_s1_valid),
    .in_sample  (r_s1),
    .dc_en      (bus.dc_en),
    .out_valid  (w_s2_valid),
    .out_sample (w_s2)
  );

  assign w_z   = w_s2 >>> bus.volume;
  assign w_z32 = {{(32-AUDIO_W-1){w_z[AUDIO_W]}}, w_z};
  assign w_sat = sat16(w_z32);

  // Attenuate, saturate, mute and publish the sample pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_audio <= '0;
      r_valid <= 1'b0;
      r_clip  <= 1'b0;
    end else begin
      r_valid <= w_s2_valid;
      if (w_s2_valid) begin
        r_audio <= bus.mute ? '0 : w_sat.val;
      end
      if (w_s2_valid && !bus.mute && w_sat.ovf) begin
        r_clip <= 1'b1;
      end else if (bus.clip_clr) begin
        r_clip <= 1'b0;
      end
    end
  end

  assign bus.audio_l      = r_audio;
  assign bus.audio_r      = r_audio;
  assign bus.sample_valid = r_valid;
  assign bus.clip         = r_clip;

endmodule

// File: tb/tb_audio_post.sv
// Self-checking bench for audio_post.
// Random windows checked against an arithmetic reference model.
module tb_audio_post;
  import audio_pkg::*;

  localparam int DL  = 4;
  localparam int DCS = 4;
  localparam int N   = 1 << DL;

  logic clk = 1'b0;
  logic reset = 1'b1;

  audio_post_if ifc ();

  audio_post #(
    .DECIM_LOG2 (DL),
    .DC_SHIFT   (DCS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  int m_dc_acc = 0;
  bit m_clip   = 1'b0;
  int m_out    = 0;

  function automatic int fdiv(input int a, input int sh);
    int d;
    int q;
    d = 1 << sh;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_dc_acc = 0;
    m_clip   = 1'b0;
    m_out    = 0;
  endtask

  task automatic model_window(input int s[N]);
    int sum;
    int avg;
    int y;
    int z;
    int o;
    bit ovf;
    sum = 0;
    for (int i = 0; i < N; i++) sum += s[i];
    avg = fdiv(sum, DL);
    if (ifc.dc_en) begin
      y = avg - fdiv(m_dc_acc, DCS);
      m_dc_acc += y;
    end else begin
      y = avg;
    end
    z = fdiv(y, int'(ifc.volume));
    ovf = 1'b0;
    o = z;
    if (z > 32767) begin
      o = 32767;
      ovf = 1'b1;
    end else if (z < -32768) begin
      o = -32768;
      ovf = 1'b1;
    end
    if (ifc.mute) o = 0;
    if (ovf && !ifc.mute) m_clip = 1'b1;
    else if (ifc.clip_clr) m_clip = 1'b0;
    m_out = o;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run_window(input int s[N], input int gap,
                            input string nm);
    bit spur;
    spur = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      ifc.ce_in = 1'b1;
      ifc.sound_in = 16'(s[i]);
      @(negedge clk);
      ifc.ce_in = 1'b0;
      if (ifc.sample_valid) spur = 1'b1;
      if (i < N - 1) begin
        repeat ($urandom_range(0, gap)) begin
          @(negedge clk);
          if (ifc.sample_valid) spur = 1'b1;
        end
      end
    end
    model_window(s);
    n_total++;
    if (spur) $display("FAIL %s early_valid: got 1 want 0", nm);
    else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      n_total++;
      if (ifc.sample_valid !== 1'(k == 3))
        $display("FAIL %s valid_t%0d: got %b want %b",
                 nm, k, ifc.sample_valid, k == 3);
      else n_pass++;
      if (k == 3) ifc.clip_clr = 1'b0;
    end
    n_total++;
    if (int'(ifc.audio_l) !== m_out)
      $display("FAIL %s audio_l: got %0d want %0d",
               nm, ifc.audio_l, m_out);
    else n_pass++;
    n_total++;
    if (int'(ifc.audio_r) !== m_out)
      $display("FAIL %s audio_r: got %0d want %0d",
               nm, ifc.audio_r, m_out);
    else n_pass++;
    n_total++;
    if (ifc.clip !== m_clip)
      $display("FAIL %s clip: got %b want %b", nm, ifc.clip, m_clip);
    else n_pass++;
  endtask

  task automatic fill(output int s[N], input int a, input int b);
    for (int i = 0; i < N; i++) s[i] = (i % 2 == 0) ? a : b;
  endtask

  task automatic test_reset();
    n_total++;
    if (ifc.audio_l !== 16'sd0 || ifc.audio_r !== 16'sd0)
      $display("FAIL reset_audio: got %0d/%0d want 0",
               ifc.audio_l, ifc.audio_r);
    else n_pass++;
    n_total++;
    if (ifc.sample_valid !== 1'b0 || ifc.clip !== 1'b0)
      $display("FAIL reset_flags: got %b%b want 00",
               ifc.sample_valid, ifc.clip);
    else n_pass++;
  endtask

  task automatic test_const();
    int s[N];
    do_reset();
    ifc.dc_en = 1'b0;
    ifc.volume = 4'd0;
    ifc.mute = 1'b0;
    fill(s, 1000, 1000);
    run_window(s, 0, "const");
    n_total++;
    if (int'(ifc.audio_l) !== 1000)
      $display("FAIL const_abs: got %0d want 1000", ifc.audio_l);
    else n_pass++;
  endtask

  task automatic test_trunc();
    int s[N];
    fill(s, 3, -4);
    run_window(s, 1, "trunc");
    n_total++;
    if (int'(ifc.audio_l) !== -1)
      $display("FAIL trunc_abs: got %0d want -1", ifc.audio_l);
    else n_pass++;
  endtask

  task automatic test_dc();
    int s[N];
    do_reset();
    ifc.dc_en = 1'b1;
    fill(s, 8000, 8000);
    for (int w = 0; w < 3; w++) run_window(s, 1, "dc");
    n_total++;
    if (int'(ifc.audio_l) !== 7032)
      $display("FAIL dc_third: got %0d want 7032", ifc.audio_l);
    else n_pass++;
    ifc.dc_en = 1'b0;
  endtask

  task automatic test_volume_mute();
    int s[N];
    do_reset();
    ifc.volume = 4'd2;
    fill(s, 1000, 1000);
    run_window(s, 0, "vol_pos");
    fill(s, -1000, -1000);
    run_window(s, 0, "vol_neg");
    n_total++;
    if (int'(ifc.audio_l) !== -250)
      $display("FAIL vol_abs: got %0d want -250", ifc.audio_l);
    else n_pass++;
    ifc.mute = 1'b1;
    fill(s, 1234, 1234);
    run_window(s, 0, "mute");
    ifc.mute = 1'b0;
    ifc.volume = 4'd0;
  endtask

  task automatic test_clip();
    int s[N];
    do_reset();
    ifc.dc_en = 1'b1;
    fill(s, -32768, -32768);
    for (int w = 0; w < 4; w++) run_window(s, 0, "clip_neg");
    fill(s, 32767, 32767);
    run_window(s, 0, "clip_sat");
    n_total++;
    if (int'(ifc.audio_l) !== 32767 || ifc.clip !== 1'b1)
      $display("FAIL clip_abs: got %0d/%b want 32767/1",
               ifc.audio_l, ifc.clip);
    else n_pass++;
    @(negedge clk);
    ifc.clip_clr = 1'b1;
    @(negedge clk);
    ifc.clip_clr = 1'b0;
    m_clip = 1'b0;
    n_total++;
    if (ifc.clip !== 1'b0)
      $display("FAIL clip_clr: got %b want 0", ifc.clip);
    else n_pass++;
    do_reset();
    fill(s, -32768, -32768);
    for (int w = 0; w < 2; w++) run_window(s, 0, "clip_pre");
    ifc.clip_clr = 1'b1;
    fill(s, 32767, 32767);
    run_window(s, 0, "clip_coinc");
    n_total++;
    if (ifc.clip !== 1'b1)
      $display("FAIL clip_coinc_abs: got %b want 1", ifc.clip);
    else n_pass++;
    ifc.dc_en = 1'b0;
  endtask

  task automatic test_reset_midwindow();
    int s[N];
    bit seen;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ifc.ce_in = 1'b1;
      ifc.sound_in = 16'sd1000;
      @(negedge clk);
      ifc.ce_in = 1'b0;
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (ifc.sample_valid) seen = 1'b1;
    end
    reset = 1'b0;
    model_reset();
    fill(s, 200, 200);
    run_window(s, 0, "rst_win");
    n_total++;
    if (seen || int'(ifc.audio_l) !== 200)
      $display("FAIL rst_win_abs: got %0d seen=%b want 200",
               ifc.audio_l, seen);
    else n_pass++;
  endtask

  task automatic test_reset_midpipe();
    bit seen;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      ifc.ce_in = 1'b1;
      ifc.sound_in = 16'sd500;
      @(negedge clk);
      ifc.ce_in = 1'b0;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ifc.sample_valid) seen = 1'b1;
    end
    n_total++;
    if (seen || ifc.audio_l !== 16'sd0)
      $display("FAIL rst_pipe: got %0d seen=%b want 0",
               ifc.audio_l, seen);
    else n_pass++;
  endtask

  task automatic test_random();
    int s[N];
    do_reset();
    for (int w = 0; w < 16; w++) begin
      for (int i = 0; i < N; i++)
        s[i] = int'($signed(16'($urandom_range(0, 65535))));
      ifc.dc_en = 1'($urandom_range(0, 1));
      ifc.volume = 4'($urandom_range(0, 15));
      ifc.mute = ($urandom_range(0, 7) == 0);
      ifc.clip_clr = ($urandom_range(0, 3) == 0);
      run_window(s, 2, "random");
    end
    ifc.dc_en = 1'b0;
    ifc.volume = 4'd0;
    ifc.mute = 1'b0;
    ifc.clip_clr = 1'b0;
  endtask

  task automatic test_hold();
    int last;
    last = m_out;
    repeat (5) @(negedge clk);
    n_total++;
    if (int'(ifc.audio_l) !== last || ifc.sample_valid !== 1'b0)
      $display("FAIL hold: got %0d/%b want %0d/0",
               ifc.audio_l, ifc.sample_valid, last);
    else n_pass++;
  endtask

  initial begin
    ifc.ce_in = 1'b0;
    ifc.sound_in = '0;
    ifc.volume = 4'd0;
    ifc.mute = 1'b0;
    ifc.dc_en = 1'b0;
    ifc.clip_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_const();
    test_trunc();
    test_hold();
    test_dc();
    test_volume_mute();
    test_clip();
    test_reset_midwindow();
    test_reset_midpipe();
    test_random();
    test_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
